sha_msg_loader: RTL
===================

# sha_msg_loader

Upstream preload stage for the rv32i SHA-256 core. Accepts a byte stream, packs it into big-endian 32-bit words and applies SHA-256 padding to one 512-bit block. It writes the 16 block words into the data-memory message area and holds the core in reset until the block is complete. Optionally it first writes the initial hash values and round constants, which replaces the bench-side memory preload.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the data-memory write port
- MSG_BASE, 100, word address of message word 0 (words MSG_BASE..MSG_BASE+15)
- MAX_BYTES, 55, largest message length that fits one padded block

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- in_valid  in  1  byte present on in_data
- in_data  in  8  message byte, first byte = most significant byte of word 0
- in_last  in  1  qualifies the final byte (valid only with in_valid)
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  data-memory word write strobe
- mem_addr  out  ADDR_W  data-memory word address
- mem_wdata  out  32  data-memory write data
- done  out  1  block fully written; sticky until reset
- err  out  1  overlength message; sticky until reset
- core_rst_n  out  1  active-low reset to core; low until done

## Operation
- States: WAIT, INIT (only with INIT_CONST_EN), RECV, PAD, LEN, DONE, ERR.
- WAIT is the reset state. The first posedge after reset release moves to INIT if compiled in, otherwise to RECV.
- RECV:
  - in_ready = 1.
  - A byte is accepted when in_valid && in_ready.
  - A 6-bit byte count cnt increments per accepted byte.
  - Byte n goes to bits [31-8*(n%4) -: 8] of the pack register.
  - Completing a word (n%4==3) issues one write of that word at MSG_BASE + n/4.
- Accepted byte with in_last:
  - If the word is partial, 0x80 is placed in the next byte lane, the remaining lanes are zeroed, and that word is written.
  - If the word is aligned (cnt%4==0 after the byte), the next word written is 0x80000000.
  - State moves to PAD.
- PAD:
  - Writes 0x00000000 to every remaining word up to and including word 13, one per cycle.
  - Moves to LEN.
- LEN:
  - Writes word 14 = 0, then word 15 = cnt*8 (bit length, zero-extended).
  - Moves to DONE.
- DONE: done=1, core_rst_n=1, in_ready=0, no further writes.
- Overlength: a byte accepted while cnt==MAX_BYTES is dropped, with or without in_last.
- ERR:
  - Entered on an overlength byte.
  - err=1, in_ready=0, no further writes, core_rst_n stays 0.
- Each of the 16 message words is written exactly once, in ascending address order.
- Zero-length messages are unsupported. The final byte must carry in_last.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, core_rst_n=0; state=WAIT, cnt=0.
- All outputs are registered. in_ready is high from the cycle after entry to RECV until the cycle after the in_last byte is accepted.
- Write latency: mem_we/mem_addr/mem_wdata are valid for exactly one cycle, the cycle after the byte that completes the word.
- Throughput: 1 byte/cycle. in_valid gaps are tolerated; nothing is written during gaps.
- After in_last: one write per cycle, no bubbles, through word 15.
- done and core_rst_n rise together, one cycle after the word-15 write.
- Asserting reset mid-operation clears everything immediately. Words already written remain in memory, and the loader restarts from WAIT.

## Configuration
- SHA_INIT_CONST_EN defined:
  - INIT state writes H0..H7 (0x6a09e667 .. 0x5be0cd19) to addresses 0..7, then K0..K63 (0x428a2f98 .. 0xc67178f2) to addresses 10..73.
  - Writes come from an internal ROM, one per cycle, 72 cycles, in_ready=0 throughout.
  - Then RECV.
- SHA_INIT_CONST_EN undefined:
  - No INIT state and no ROM; constants must be preloaded externally.
  - RECV is entered at the first posedge after reset release.

## Test plan
- "hello world" (11 bytes, last on 'd'):
  - writes 100=0x68656c6c, 101=0x6f20776f, 102=0x726c6480;
  - 103..114=0; 115=0x00000058;
  - then done=1, core_rst_n=1.
- "abcd" (aligned):
  - 100=0x61626364, 101=0x80000000;
  - 102..114=0; 115=0x00000020.
- 55 bytes 0x00..0x36:
  - 113=0x34353680, 114=0, 115=0x000001B8;
  - no cycle with in_ready=1 after the last byte.
- 56 bytes without in_last: err=1 after byte 56; 0 further writes; done=0; core_rst_n=0.
- "hello world" with random in_valid gaps, and with reset pulsed after byte 6:
  - gaps: identical 16 writes;
  - reset pulse: outputs return to reset values, and a fresh message loads correctly.
- SHA_INIT_CONST_EN:
  - writes 0=0x6a09e667, 7=0x5be0cd19, 10=0x428a2f98, 73=0xc67178f2;
  - in_ready=0 for all 72 INIT cycles, then the message loads as in the first case.

Source files
------------

// File: rtl/sha_msg_loader.sv
// sha_msg_loader: packs a byte stream into big-endian 32-bit words, applies
// SHA-256 padding for a single 512-bit block and writes the 16 block words
// into the data-memory message area. It holds the SHA core in reset until
// the block is complete.
//
// Optional feature macro: SHA_INIT_CONST_EN
//   When defined, an INIT phase first writes H0..H7 to addresses 0..7 and
//   K0..K63 to addresses 10..73 from an internal ROM. When undefined, there
//   is no INIT state and no ROM, so the constants must be preloaded elsewhere.
module sha_msg_loader #(
    parameter int ADDR_W    = 10,
    parameter int MSG_BASE  = 100,
    parameter int MAX_BYTES = 55
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic              core_rst_n
);

`ifdef SHA_INIT_CONST_EN
    typedef enum logic [2:0] {
        S_WAIT, S_INIT, S_RECV, S_PAD, S_LEN, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] H_TAB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ROM entries 0..7 are the initial hash values, 8..71 the round constants.
    function automatic logic [31:0] rom_word(input logic [6:0] idx);
        logic [6:0] k_idx;
        k_idx = idx - 7'd8;
        if (idx < 7'd8) return H_TAB[idx[2:0]];
        else            return K_TAB[k_idx[5:0]];
    endfunction

    // Hash values sit at 0..7; round constants start at 10, leaving a gap of two.
    function automatic logic [ADDR_W-1:0] rom_addr(input logic [6:0] idx);
        if (idx < 7'd8) return ADDR_W'(idx);
        else            return ADDR_W'(idx) + ADDR_W'(2);
    endfunction

    logic [6:0] rom_idx;
`else
    typedef enum logic [2:0] {
        S_WAIT, S_RECV, S_PAD, S_LEN, S_DONE, S_ERR
    } state_t;
`endif

    localparam logic [5:0] MAX_CNT = 6'(MAX_BYTES);

    state_t      state;
    logic [5:0]  cnt;       // bytes accepted so far
    logic [31:0] pack;      // word under assembly
    logic [3:0]  word_idx;  // next message word to write in PAD/LEN
    logic        pad_mark;  // next PAD write carries the 0x80 marker
    logic [31:0] merged;    // pack with the current byte (and marker) inserted

    function automatic logic [ADDR_W-1:0] msg_addr(input logic [3:0] w);
        return ADDR_W'(MSG_BASE) + ADDR_W'(w);
    endfunction

    // Insert the incoming byte into its lane; the following lane gets the
    // 0x80 marker and later lanes are zero, which is the padded form of a
    // partial final word. For lane 3 this is simply the completed word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        merged = pack;
        case (cnt[1:0])
            2'd0:    merged = {in_data, 8'h80, 16'h0000};
            2'd1:    merged = {pack[31:24], in_data, 8'h80, 8'h00};
            2'd2:    merged = {pack[31:16], in_data, 8'h80};
            default: merged = {pack[31:8], in_data};
        endcase
    end

    // Control FSM with registered outputs: packing, padding and length writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_WAIT;
            cnt        <= '0;
            pack       <= '0;
            word_idx   <= '0;
            pad_mark   <= 1'b0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
`ifdef SHA_INIT_CONST_EN
            rom_idx    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every branch sees pre-edge register values.
            mem_we <= 1'b0;
            case (state)
                S_WAIT: begin
`ifdef SHA_INIT_CONST_EN
                    state   <= S_INIT;
                    rom_idx <= '0;
`else
                    state   <= S_RECV;
`endif
                end

`ifdef SHA_INIT_CONST_EN
                S_INIT: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= rom_addr(rom_idx);
                    mem_wdata <= rom_word(rom_idx);
                    rom_idx   <= rom_idx + 7'd1;
                    if (rom_idx == 7'd71) state <= S_RECV;
                end
`endif

                S_RECV: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (cnt == MAX_CNT) begin
                            // Overlength byte: dropped, loader stops for good.
                            state    <= S_ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            cnt  <= cnt + 6'd1;
                            pack <= merged;
                            if (in_last || cnt[1:0] == 2'd3) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= msg_addr(cnt[5:2]);
                                mem_wdata <= merged;
                            end
                            if (in_last) begin
                                in_ready <= 1'b0;
                                word_idx <= cnt[5:2] + 4'd1;
                                // An aligned final byte leaves the marker for a word of its own.
                                pad_mark <= (cnt[1:0] == 2'd3);
                                state    <= (cnt[5:2] == 4'd13) ? S_LEN : S_PAD;
                            end
                        end
                    end
                end

                S_PAD: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= msg_addr(word_idx);
                    mem_wdata <= pad_mark ? 32'h8000_0000 : 32'h0000_0000;
                    pad_mark  <= 1'b0;
                    word_idx  <= word_idx + 4'd1;
                    if (word_idx == 4'd13) state <= S_LEN;
                end

                S_LEN: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= msg_addr(word_idx);
                    mem_wdata <= (word_idx == 4'd15) ? {23'd0, cnt, 3'd0} : 32'h0000_0000;
                    word_idx  <= word_idx + 4'd1;
                    if (word_idx == 4'd15) state <= S_DONE;
                end

                S_DONE: begin
                    done       <= 1'b1;
                    core_rst_n <= 1'b1;
                    in_ready   <= 1'b0;
                end

                S_ERR: begin
                    err      <= 1'b1;
                    in_ready <= 1'b0;
                end

                default: state <= S_WAIT;
            endcase
        end
    end

endmodule
